// File: rtl/oddeven_sched.sv
// oddeven_sched: N serial channels share one odd/even run-length detector via a
// round-robin arbiter. Per-channel detector state lives in a local table.
`default_nettype none

module oddeven_sched #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int CW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_i,
  input  logic [N-1:0]   bit_in_i,
  input  logic [N-1:0]   en_i,
  input  logic [N-1:0]   clr_i,
  output logic [N-1:0]   gnt_o,
  output logic           hit_vld_o,
  output logic           hit_o,
  output logic [IDW-1:0] hit_ch_o,
  output logic [CW-1:0]  hit_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S1   = 2'b01,
    S2   = 2'b11,
    S3   = 2'b10
  } det_state_t;

  det_state_t         state_q [N];
  logic [IDW-1:0]     ptr_q;
  logic               hit_vld_q;
  logic               hit_q;
  logic [IDW-1:0]     hit_ch_q;
  logic [CW-1:0]      hit_cnt_q;

  logic [N-1:0]       elig;
  logic [N-1:0]       gnt;
  logic               gvalid;
  logic [IDW-1:0]     gidx;
  logic [IDW-1:0]     ptr_d;
  det_state_t         cur_st;
  det_state_t         nxt_st_d;
  logic               b;
  logic               z;

  assign elig = req_i & en_i & ~clr_i;

  // Search from ptr upward, wrapping mod N; first eligible channel wins.
  always_comb begin
    int idx;
    gnt    = '0;
    gvalid = 1'b0;
    gidx   = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!gvalid && elig[idx]) begin
        gvalid    = 1'b1;
        gidx      = IDW'(idx);
        gnt[idx]  = 1'b1;
      end
    end
  end

  assign ptr_d = (gidx == IDW'(N - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    cur_st   = state_q[gidx];
    b        = bit_in_i[gidx];
    nxt_st_d = IDLE;
    z        = 1'b0;
    case (cur_st)
      IDLE: nxt_st_d = b ? S2 : S1;
      S1: begin
        nxt_st_d = b ? S2 : IDLE;
        z        = b;
      end
      S2:   nxt_st_d = b ? S3 : S1;
      S3: begin
        nxt_st_d = b ? S2 : S1;
        z        = ~b;
      end
      default: nxt_st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) state_q[i] <= IDLE;
      ptr_q     <= '0;
      hit_vld_q <= 1'b0;
      hit_q     <= 1'b0;
      hit_ch_q  <= '0;
      hit_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr_i[i]) begin
          state_q[i] <= IDLE;
        end else if (gvalid && (gidx == IDW'(i))) begin
          state_q[i] <= nxt_st_d;
        end
      end
      hit_vld_q <= gvalid;
      if (gvalid) begin
        ptr_q    <= ptr_d;
        hit_q    <= z;
        hit_ch_q <= gidx;
        // Counter tracks results as they are registered, saturating at all-ones.
        if (z && (hit_cnt_q != {CW{1'b1}})) hit_cnt_q <= hit_cnt_q + 1'b1;
      end
    end
  end

  assign gnt_o     = gnt;
  assign hit_vld_o = hit_vld_q;
  assign hit_o     = hit_q;
  assign hit_ch_o  = hit_ch_q;
  assign hit_cnt_o = hit_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_oddeven_sched.sv
// Directed table-driven bench for oddeven_sched plus reset and saturation sequences.
`default_nettype none

module tb_oddeven_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0, bits = '0, en = '0, clr = '0;
  logic [3:0] gnt;
  logic       hit_vld, hit;
  logic [1:0] hit_ch;
  logic [7:0] hit_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oddeven_sched #(.N(4), .IDW(2), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .bit_in_i(bits), .en_i(en), .clr_i(clr),
    .gnt_o(gnt), .hit_vld_o(hit_vld), .hit_o(hit),
    .hit_ch_o(hit_ch), .hit_cnt_o(hit_cnt)
  );

  typedef struct packed {
    logic [3:0] req, bits, en, clr, gnt;
    logic       vld, hit;
    logic [1:0] ch;
    logic [7:0] cnt;
  } vec_t;

  vec_t tv [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] b,
                       input logic [3:0] e, input logic [3:0] c);
    @(negedge clk);
    req = r; bits = b; en = e; clr = c;
    #1;
  endtask

  initial begin
    //             req      bits     en       clr      gnt      vld  hit  ch     cnt
    tv[0]  = '{4'b0001, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 8'd0};
    tv[1]  = '{4'b0001, 4'b0001, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 8'd1};
    tv[2]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 8'd1};
    tv[3]  = '{4'b0010, 4'b0010, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd1, 8'd1};
    tv[4]  = '{4'b0010, 4'b0010, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd1, 8'd1};
    tv[5]  = '{4'b0010, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1, 8'd2};
    tv[6]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 8'd2};
    tv[7]  = '{4'b0010, 4'b0010, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd1, 8'd2};
    tv[8]  = '{4'b0010, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd1, 8'd2};
    tv[9]  = '{4'b0101, 4'b0100, 4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2, 8'd2};
    tv[10] = '{4'b0101, 4'b0100, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 8'd2};
    tv[11] = '{4'b0101, 4'b0101, 4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2, 8'd2};
    tv[12] = '{4'b0101, 4'b0001, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 8'd3};
    tv[13] = '{4'b0100, 4'b0000, 4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 8'd4};
    tv[14] = '{4'b1000, 4'b0000, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, 2'd3, 8'd4};
    tv[15] = '{4'b1001, 4'b1000, 4'b1111, 4'b1000, 4'b0001, 1'b1, 1'b0, 2'd0, 8'd4};
    tv[16] = '{4'b1000, 4'b1000, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, 2'd3, 8'd4};
    tv[17] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 8'd4};
    tv[18] = '{4'b1111, 4'b0000, 4'b1101, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2, 8'd4};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 32'(hit_vld), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_ch", 32'(hit_ch), 32'd0);
    check("rst_cnt", 32'(hit_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tv[i].req, tv[i].bits, tv[i].en, tv[i].clr);
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_vld", i), 32'(hit_vld), 32'(tv[i].vld));
      check($sformatf("v%0d_hit", i), 32'(hit), 32'(tv[i].hit));
      check($sformatf("v%0d_ch", i), 32'(hit_ch), 32'(tv[i].ch));
      check($sformatf("v%0d_cnt", i), 32'(hit_cnt), 32'(tv[i].cnt));
    end

    // Leave ch2 mid-run (S1), pointer at 3, then reset asynchronously.
    drive(4'b0100, 4'b0000, 4'b1111, 4'b0000);
    check("pre_gnt", 32'(gnt), 32'b0100);
    @(posedge clk);
    #1;
    check("pre_vld", 32'(hit_vld), 32'd1);
    drive(4'b1100, 4'b0100, 4'b1111, 4'b0000);
    #1;
    rst = 1'b0;
    #1;
    check("arst_vld", 32'(hit_vld), 32'd0);
    check("arst_ch", 32'(hit_ch), 32'd0);
    check("arst_cnt", 32'(hit_cnt), 32'd0);
    @(posedge clk);
    #1;
    check("inrst_vld", 32'(hit_vld), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_gnt", 32'(gnt), 32'b0100);
    @(posedge clk);
    #1;
    check("post_vld", 32'(hit_vld), 32'd1);
    check("post_hit", 32'(hit), 32'd0);
    check("post_ch", 32'(hit_ch), 32'd2);
    drive(4'b1000, 4'b0000, 4'b1111, 4'b0000);
    check("post2_gnt", 32'(gnt), 32'b1000);
    @(posedge clk);
    #1;
    check("post2_ch", 32'(hit_ch), 32'd3);

    // Saturation: each (0,1) pair on ch0 yields exactly one hit.
    for (int p = 1; p <= 260; p++) begin
      drive(4'b0001, 4'b0000, 4'b1111, 4'b0000);
      @(posedge clk);
      drive(4'b0001, 4'b0001, 4'b1111, 4'b0000);
      @(posedge clk);
      #1;
      if (p == 1 || p == 100 || p == 254 || p == 255 || p == 260) begin
        check($sformatf("sat_p%0d_hit", p), 32'(hit), 32'd1);
        check($sformatf("sat_p%0d_cnt", p), 32'(hit_cnt), (p > 255) ? 32'd255 : 32'(p));
      end
    end
    drive(4'b0000, 4'b0000, 4'b1111, 4'b0000);
    @(posedge clk);
    #1;
    check("sat_final_cnt", 32'(hit_cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/oddeven_sched.md
# oddeven_sched

Shared odd/even run-length detector scheduler. Up to N serial bit-stream channels time-share one odd/even detector datapath. Per-channel detector state is held in a local state table, and a round-robin arbiter grants one bit per cycle. Each processed bit produces one registered result tagged with its channel. The block sits between the serial front-end channels and the result collector.

## Interface
- N, 4, number of requester channels (2..8)
- IDW, 2, channel-id width, equal to clog2(N)
- CW, 8, width of the hit counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  N  per-channel request; bit_in[i] valid while req[i]=1
- bit_in  in  N  per-channel serial data bit
- en  in  N  per-channel enable; en[i]=0 masks req[i]
- clr  in  N  per-channel synchronous state clear
- gnt  out  N  one-hot grant, combinational; bit_in[i] is consumed at the clock edge where gnt[i]=1
- hit_vld  out  1  registered; a result is present this cycle
- hit  out  1  registered detector output for the processed bit
- hit_ch  out  IDW  registered channel id of the result
- hit_cnt  out  CW  registered saturating count of hit=1 results

## Operation
- Detector states, 2-bit Gray-coded: IDLE=00, S1=01 (odd run of 0s), S2=11 (odd run of 1s), S3=10 (even run of 1s, length ≥2).
- Transitions and output per processed bit b:
  - IDLE: b=1 goes to S2; b=0 goes to S1; z=0.
  - S1: b=1 goes to S2 with z=1; b=0 goes to IDLE with z=0.
  - S2: b=1 goes to S3; b=0 goes to S1; z=0.
  - S3: b=1 goes to S2 with z=0; b=0 goes to S1 with z=1.
- State table: one 2-bit entry per channel. Only the granted channel's entry updates in a cycle.
- Eligibility: elig[i] = req[i] & en[i] & ~clr[i].
- Arbitration: round-robin pointer ptr (IDW bits). The search starts at ptr and increments mod N. The first eligible channel g gets gnt[g]=1. After a grant, ptr becomes (g+1) mod N. With no eligible channel, gnt=0 and ptr holds.
- Requester rule: hold req[i] and bit_in[i] stable until gnt[i] is seen. Drop req[i] or present the next bit in the cycle after the grant.
- clr[i]=1: entry i is set to IDLE at the edge. Channel i gets no grant that cycle, and its pending bit waits.
- en[i]=0 leaves entry i untouched.
- Result: on a grant, at the edge, hit_vld<=1, hit<=z, hit_ch<=g. With no grant, hit_vld<=0 and hit and hit_ch hold.
- hit_cnt increments on each registered hit=1 result and saturates at 2^CW-1. Only rst clears it.

## Timing
- Reset (rst=0, asynchronous):
  - all state entries IDLE, ptr=0
  - hit_vld=0, hit=0, hit_ch=0, hit_cnt=0
  - gnt follows its combinational logic but nothing is consumed while rst=0
- Grant-to-result latency: 1 cycle. Bit consumed at edge k gives hit_vld=1 in cycle k+1.
- Throughput: 1 bit per cycle aggregate. Each of M continuously eligible channels gets exactly 1 grant every M cycles.
- Wrap-around: a grant to channel N-1 sets ptr=0.
- Reset mid-stream clears all history. The first bit after release is processed from IDLE.
- clr and req on the same channel in the same cycle: clr wins. The grant goes to the next eligible channel, and ptr advances from that winner.

## Test plan
- Single channel 0, en=1, bits 0 then 1:
  - gnt=0001 in both cycles
  - results hit=0 then hit=1, hit_ch=0 on the second
  - hit_cnt=1
- Channel 1 alone, bits 1,1,0: results 0,0,1 with hit_ch=1. Then bits 1,0 give 0,0 (odd run of 1s gives no hit).
- Channels 0 and 2 requesting continuously, ch0 stream 0,1 and ch2 stream 1,1,0:
  - gnt alternates 0001,0100,0001,0100,…
  - hit on ch0's 2nd bit and ch2's 3rd bit
  - state independence: ch0 run is not corrupted by ch2
- Channel 3 bits 0 then asserts clr[3] with req held, then bit 1:
  - no grant to ch3 in the clr cycle
  - after clr, bit 1 from IDLE gives hit=0
- Reset pulse asserted mid-stream:
  - all outputs return to 0 immediately
  - ptr=0, so the first grant goes to the lowest eligible channel
  - prior runs are forgotten
- Drive 260 hit-producing bit pairs: hit_cnt saturates at 255 and does not wrap.
